// File: rtl/soc_pkg.sv
// Shared types and constants for the instruction fetch/decode block:
// the FSM state encoding, the decoded instruction fields, and the bus widths.
package soc_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 256;
  localparam int INSTR_W = 32;

  localparam logic [7:0] OP_STOP = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    HALT
  } fsm_state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_fields_t;

  // Field order in the struct matches the instruction word, most significant byte first.
  function automatic instr_fields_t decode_instr(input logic [INSTR_W-1:0] word);
    return instr_fields_t'(word);
  endfunction

endpackage

// File: rtl/instruction_fetch_decode_if.sv
// Instruction-memory read bus plus the decoded-instruction handshake to execute.
// The master modport is the fetch/decode side; the slave modport is memory plus execute.
interface instruction_fetch_decode_if;
  import soc_pkg::*;

  logic [DATA_W-1:0] InstructDataOut;
  logic [ADDR_W-1:0] address;
  logic              nRead;

  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        opcode;
  logic [7:0]        dest;
  logic [7:0]        src1;
  logic [7:0]        src2;

  modport master (
    input  InstructDataOut, instr_ready,
    output address, nRead, instr_valid, opcode, dest, src1, src2
  );

  modport slave (
    output InstructDataOut, instr_ready,
    input  address, nRead, instr_valid, opcode, dest, src1, src2
  );

endinterface

// File: rtl/instruction_fetch_decode.sv
// Fetches 32-bit instruction words from a fixed-latency memory, splits them into
// opcode/dest/src1/src2 and hands each one to execute with a valid/ready handshake.
module instruction_fetch_decode
  import soc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] INSTR_BASE  = 16'h1000,
  parameter logic [ADDR_W-1:0] INSTR_DEPTH = 16'd64,
  parameter int unsigned       READ_LAT    = 1
) (
  input  logic                        Clk,
  input  logic                        nReset,
  instruction_fetch_decode_if.master  bus,
  output logic                        halt,
  output logic                        fetch_overrun,
  output logic [15:0]                 instr_count
);

  localparam logic [ADDR_W-1:0] PC_END   = INSTR_BASE + INSTR_DEPTH;
  localparam logic [2:0]        LAT_LAST = 3'(READ_LAT - 1);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        lat_q, lat_d;
  instr_fields_t     fields_q, fields_d;
  logic [15:0]       count_q, count_d;
  logic              halt_q, halt_d;
  logic              overrun_q, overrun_d;

  logic [ADDR_W-1:0] pc_inc;
  logic              bus_active;

  // Only the low instruction word of the wide memory bus carries information.
  logic unused_data_bits;
  assign unused_data_bits = ^bus.InstructDataOut[DATA_W-1:INSTR_W];

  assign pc_inc = pc_q + 16'd1;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    lat_d     = lat_q;
    fields_d  = fields_q;
    count_d   = count_q;
    halt_d    = halt_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        lat_d   = 3'd0;
        state_d = WAIT;
      end

      WAIT: begin
        if (lat_q == LAT_LAST) begin
          fields_d = decode_instr(bus.InstructDataOut[INSTR_W-1:0]);
          state_d  = ISSUE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      ISSUE: begin
        if (bus.instr_ready) begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          pc_d    = pc_inc;
          // A stop word ends cleanly even when it is also the last word in range.
          if (fields_q.opcode == OP_STOP) begin
            halt_d  = 1'b1;
            state_d = HALT;
          end else if (pc_inc == PC_END) begin
            overrun_d = 1'b1;
            state_d   = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      pc_q      <= INSTR_BASE;
      lat_q     <= 3'd0;
      fields_q  <= '0;
      count_q   <= 16'd0;
      halt_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge
      // values, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      lat_q     <= lat_d;
      fields_q  <= fields_d;
      count_q   <= count_d;
      halt_q    <= halt_d;
      overrun_q <= overrun_d;
    end
  end

  // The read strobe and address stay up from the fetch cycle through the capture cycle.
  assign bus_active      = (state_q == FETCH) || (state_q == WAIT);
  assign bus.address     = bus_active ? pc_q : '0;
  assign bus.nRead       = !bus_active;

  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.opcode      = fields_q.opcode;
  assign bus.dest        = fields_q.dest;
  assign bus.src1        = fields_q.src1;
  assign bus.src2        = fields_q.src2;

  assign halt            = halt_q;
  assign fetch_overrun   = overrun_q;
  assign instr_count     = count_q;

endmodule

// File: doc/instruction_fetch_decode.md
INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

Interface
REQ-001 Parameter INSTR_BASE, default 16'h1000, SHALL set the bus address of the first instruction word.
REQ-002 Parameter INSTR_DEPTH, default 16'd64, SHALL set the number of fetchable instruction words.
REQ-003 Parameter READ_LAT, default 1, range 1..7, SHALL set the cycles from the nRead-low edge to valid InstructDataOut.
REQ-004 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 nReset  input  1  reset; asynchronous assert, active-low.
REQ-006 InstructDataOut  input  256  instruction memory read data; only bits [31:0] are used.
REQ-007 address  output  16  bus address, driven only while fetching, else 16'h0000.
REQ-008 nRead  output  1  active-low read strobe to instruction memory.
REQ-009 instr_ready  input  1  execution stage accepts the presented instruction.
REQ-010 instr_valid  output  1  decoded instruction fields are valid.
REQ-011 opcode, dest, src1, src2  output  8 each  instruction bits [31:24], [23:16], [15:8], [7:0].
REQ-012 halt  output  1  stop instruction issued and accepted; fetching ended.
REQ-013 fetch_overrun  output  1  INSTR_DEPTH words fetched with no stop instruction.
REQ-014 instr_count  output  16  count of accepted instructions, saturating at 16'hFFFF.

Function
REQ-015 The FSM SHALL use states IDLE, FETCH, WAIT, ISSUE and HALT.
REQ-016 IDLE SHALL move to FETCH on the first clock after reset release, with pc = INSTR_BASE.
REQ-017 FETCH SHALL last exactly one cycle, driving address = pc and nRead = 0, then move to WAIT.
REQ-018 In FETCH and WAIT, nRead SHALL be 0 on every cycle before data capture and 1 in every other state.
REQ-019 WAIT SHALL count READ_LAT cycles, latch InstructDataOut[31:0] into the field registers on the final WAIT cycle, then move to ISSUE.
REQ-020 ISSUE SHALL hold instr_valid = 1, with all fields stable, until a cycle in which instr_ready = 1.
REQ-021 An accepted instruction SHALL increment instr_count, deassert instr_valid on the next cycle and increment pc by 1.
REQ-022 After acceptance, an opcode of 8'hFF (stop, word 32'hFF000000) SHALL move the FSM to HALT; any other opcode SHALL move it to FETCH.
REQ-023 HALT SHALL be terminal until reset: halt = 1, nRead = 1, instr_valid = 0.
REQ-024 The FSM SHALL go to HALT with fetch_overrun = 1 (halt = 0) instead of FETCH when the incremented pc equals INSTR_BASE + INSTR_DEPTH.
REQ-025 instr_ready asserted outside ISSUE SHALL be ignored.
REQ-026 Minimum fetch-to-accept latency SHALL be 1 + READ_LAT + 1 cycles when instr_ready is held high.
REQ-027 Fields SHALL not change while instr_valid = 1, regardless of InstructDataOut activity.

Reset
REQ-028 nReset low SHALL immediately force: state IDLE, pc INSTR_BASE, nRead 1, address 0, instr_valid 0, all fields 0, halt 0, fetch_overrun 0, instr_count 0.
REQ-029 A reset asserted mid-operation (any state) SHALL abandon the in-flight fetch or issue and discard the latched instruction.
REQ-030 After reset release, fetching SHALL restart at INSTR_BASE.

Structure
REQ-031 Shared package soc_pkg SHALL hold the state enum, the instruction field struct, the OP_STOP = 8'hFF constant and the bus width constants (ADDR_W = 16, DATA_W = 256).
REQ-032 The module SHALL be a single module with no sub-modules, and the READ_LAT counter SHALL be 3 bits wide.

Verification
REQ-033 Program words 32'h01020304, 32'h10000102, 32'hFF000000 at INSTR_BASE, instr_ready = 1 -> three issues, halt = 1, instr_count = 3, addresses 1000/1001/1002.
REQ-034 instr_ready held 0 for 5 cycles in ISSUE -> instr_valid and fields stay constant; one increment of instr_count on acceptance.
REQ-035 READ_LAT = 3 -> nRead low for 4 cycles per fetch; data captured on the third WAIT cycle.
REQ-036 INSTR_DEPTH = 4 and no stop word -> after 4 acceptances, fetch_overrun = 1, halt = 0, nRead stays 1.
REQ-037 nReset pulsed low during WAIT of the second fetch -> all outputs at their reset values asynchronously; the next fetch uses address 16'h1000.
REQ-038 instr_ready pulsed in FETCH/WAIT -> no count change, no premature issue.
